stp_block_sr: RTL and testbench

Parametrised word-serial to block-parallel collector with valid/ready handshakes on both sides.
- Gathers NUM_WORDS words of WORD_W bits into one block, then hands the block to an output holding register.
- The next block can fill while the downstream stage (e.g. the SHA message-schedule loader) is still stalled.
- Successor to the fixed 8x32 serial-to-parallel register; adds selectable fill order, fill count, flush and back-pressure.

---
 rtl/stp_block_sr.sv | 87 ++++++++
 tb/tb_stp_block_sr.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stp_block_sr.sv
// Word-serial to block-parallel collector. Words are shifted into a collect
// register; each completed block moves to a holding register so the next
// block can start filling while the downstream stage is still stalled.
module stp_block_sr #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_data,
    output logic [CNT_W-1:0]            fill_count
);

    localparam int               BLK_W     = WORD_W * NUM_WORDS;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_WORDS - 1);

    logic [BLK_W-1:0] sr;
    logic [BLK_W-1:0] sr_next;
    logic             accept;
    logic             completing;
    logic             consume;

    // Only the block-completing word can stall, and only while the holding
    // register is full and not being drained this cycle.
    assign in_ready   = (fill_count != LAST_SLOT) || !out_valid || out_ready;
    assign accept     = in_valid && in_ready && !flush;
    assign completing = accept && (fill_count == LAST_SLOT);
    assign consume    = out_valid && out_ready;

    // Shift direction decides whether the first word ends up in the top or
    // the bottom word slot of the finished block.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_next = {sr[BLK_W-WORD_W-1:0], in_data};
        end else begin : g_lsb_first
            assign sr_next = {in_data, sr[BLK_W-1:WORD_W]};
        end
    endgenerate

    // Collect register: shifts on every accepted word, never cleared by a
    // completion because the next NUM_WORDS accepts overwrite it entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (accept) begin
            sr <= sr_next;
        end
    end

    // Fill counter: flush discards the partial block, completion restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_count <= '0;
        end else if (flush) begin
            fill_count <= '0;
        end else if (accept) begin
            if (completing) begin
                fill_count <= '0;
            end else begin
                fill_count <= fill_count + CNT_W'(1);
            end
        end
    end

    // Holding register: a new block may load in the same edge the previous
    // one is consumed, keeping out_valid high for full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (completing) begin
            out_data  <= sr_next;
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stp_block_sr.sv
// Self-checking bench for stp_block_sr: an MSB-first and an LSB-first
// instance share stimulus and are compared against a queue-based model.
module tb_stp_block_sr;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int BW = W * N;

    logic          tb_clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  in_data;

    logic          in_ready_m, in_ready_l;
    logic          out_valid_m, out_valid_l;
    logic [BW-1:0] out_data_m, out_data_l;
    logic [2:0]    fill_count_m, fill_count_l;

    int checks = 0;
    int errors = 0;

    // Reference model state: words of the partial block in arrival order,
    // plus the pending block as seen by each fill order.
    logic [W-1:0]  mq[$];
    bit            m_pv;
    logic [BW-1:0] m_pd_m;
    logic [BW-1:0] m_pd_l;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic [2:0]   exp_cnt;
        logic         exp_ov;
        logic         exp_rdy;
    } vec_t;

    vec_t vecs[N];

    stp_block_sr #(.WORD_W(W), .NUM_WORDS(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk(tb_clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
        .fill_count(fill_count_m)
    );

    stp_block_sr #(.WORD_W(W), .NUM_WORDS(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(tb_clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
        .fill_count(fill_count_l)
    );

    // Free-running bench clock.
    always #5 tb_clk = ~tb_clk;

    task automatic check_output(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_ready(input bit ordy);
        return (mq.size() != N - 1) || !m_pv || ordy;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pv   = 1'b0;
        m_pd_m = '0;
        m_pd_l = '0;
    endtask

    // One edge of the model: a block is simply the last N accepted words.
    task automatic model_step(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        bit rdy;
        bit done;
        rdy  = model_ready(ordy);
        done = 1'b0;
        if (fl) begin
            mq.delete();
        end else if (iv && rdy) begin
            mq.push_back(d);
            if (mq.size() == N) begin
                for (int i = 0; i < N; i++) begin
                    m_pd_m[(N-1-i)*W +: W] = mq[i];
                    m_pd_l[i*W +: W]       = mq[i];
                end
                m_pv = 1'b1;
                done = 1'b1;
                mq.delete();
            end
        end
        if (m_pv && ordy && !done) m_pv = 1'b0;
    endtask

    task automatic compare_all();
        check_output("fill_count_msb", BW'(fill_count_m), BW'(mq.size()));
        check_output("fill_count_lsb", BW'(fill_count_l), BW'(mq.size()));
        check_output("out_valid_msb", BW'(out_valid_m), BW'(m_pv));
        check_output("out_valid_lsb", BW'(out_valid_l), BW'(m_pv));
        check_output("out_data_msb", out_data_m, m_pd_m);
        check_output("out_data_lsb", out_data_l, m_pd_l);
    endtask

    // Drive one cycle of inputs, check the combinational ready before the
    // edge, advance the model, then check registered outputs after the edge.
    task automatic apply_stimulus(input bit iv, input logic [W-1:0] d, input bit ordy,
                                  input bit fl, output logic rdy_seen);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy_seen = in_ready_m;
        check_output("in_ready_msb", BW'(in_ready_m), BW'(model_ready(ordy)));
        check_output("in_ready_lsb", BW'(in_ready_l), BW'(model_ready(ordy)));
        model_step(iv, d, ordy, fl);
        @(posedge tb_clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic          rdy;
        logic [BW-1:0] exp_m;
        logic [BW-1:0] exp_l;
        int            low_cnt;
        int            blk_cnt;
        int            blk_idx[$];
        bit            has_dead;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        model_reset();
        repeat (2) @(posedge tb_clk);
        #1;
        compare_all();
        rst = 1'b0;
        #1;
        check_output("ready_after_reset", BW'(in_ready_m), BW'(1));

        // Words 1..8 with the output always draining.
        for (int k = 0; k < N; k++) begin
            vecs[k].iv      = 1'b1;
            vecs[k].d       = W'(k + 1);
            vecs[k].ordy    = 1'b1;
            vecs[k].fl      = 1'b0;
            vecs[k].exp_cnt = 3'((k + 1) % N);
            vecs[k].exp_ov  = (k == N - 1);
            vecs[k].exp_rdy = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            apply_stimulus(vecs[k].iv, vecs[k].d, vecs[k].ordy, vecs[k].fl, rdy);
            check_output("vec_ready", BW'(rdy), BW'(vecs[k].exp_rdy));
            check_output("vec_fill_count", BW'(fill_count_m), BW'(vecs[k].exp_cnt));
            check_output("vec_out_valid", BW'(out_valid_m), BW'(vecs[k].exp_ov));
        end
        for (int k = 0; k < N; k++) begin
            exp_m[k*W +: W] = W'(N - k);
            exp_l[k*W +: W] = W'(k + 1);
        end
        check_output("block_msb_order", out_data_m, exp_m);
        check_output("block_lsb_order", out_data_l, exp_l);

        // Asynchronous reset in mid-cycle with a block still pending.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'h12345678;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("ready_after_midreset", BW'(in_ready_m), BW'(1));

        // Back-pressure: block A held, block B stalls on its last word.
        for (int k = 0; k < N; k++) apply_stimulus(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, rdy);
        for (int k = 0; k < N - 1; k++) apply_stimulus(1'b1, 32'h55555555, 1'b0, 1'b0, rdy);
        repeat (2) begin
            apply_stimulus(1'b1, 32'h55555555, 1'b0, 1'b0, rdy);
            check_output("stall_ready", BW'(rdy), BW'(0));
            check_output("stall_fill_count", BW'(fill_count_m), BW'(N - 1));
            check_output("stall_hold_a", out_data_m, {N{32'hAAAAAAAA}});
        end
        apply_stimulus(1'b1, 32'h55555555, 1'b1, 1'b0, rdy);
        check_output("swap_valid", BW'(out_valid_m), BW'(1));
        check_output("swap_block_b", out_data_m, {N{32'h55555555}});

        // Flush a partial block while block B is still pending.
        repeat (3) apply_stimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, rdy);
        apply_stimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, rdy);
        check_output("flush_fill_count", BW'(fill_count_m), BW'(0));
        check_output("flush_keeps_valid", BW'(out_valid_m), BW'(1));
        check_output("flush_keeps_data", out_data_m, {N{32'h55555555}});
        for (int k = 0; k < N; k++) apply_stimulus(1'b1, W'(k), 1'b1, 1'b0, rdy);
        has_dead = 1'b0;
        for (int k = 0; k < N; k++) if (out_data_m[k*W +: W] == 32'hDEADBEEF) has_dead = 1'b1;
        check_output("flush_no_stale", BW'(has_dead), BW'(0));
        apply_stimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, rdy);
        check_output("flush_consume_valid", BW'(out_valid_m), BW'(0));
        check_output("flush_consume_count", BW'(fill_count_m), BW'(0));

        // Sustained random stream at full throughput.
        low_cnt = 0;
        blk_cnt = 0;
        for (int i = 0; i < 5 * N; i++) begin
            apply_stimulus(1'b1, W'($urandom), 1'b1, 1'b0, rdy);
            if (rdy !== 1'b1) low_cnt++;
            if (out_valid_m === 1'b1) begin
                blk_cnt++;
                blk_idx.push_back(i);
            end
        end
        check_output("stream_ready_low", BW'(low_cnt), BW'(0));
        check_output("stream_blocks", BW'(blk_cnt), BW'(5));
        for (int b = 0; b < blk_idx.size(); b++) begin
            check_output("stream_spacing", BW'(blk_idx[b]), BW'(N * (b + 1) - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
